// File: rtl/ack_fifo_ctrl_if.sv
// User-side handshake bundle for ack_fifo_ctrl: push/pop requests, pop data and status flags.
interface ack_fifo_ctrl_if;
  logic        WE;
  logic [15:0] DATA;
  logic        RE;
  logic [15:0] Q;
  logic        DVALID;
  logic        FULL;
  logic        EMPTY;
  logic        AFULL;
  logic        OVF;
  logic        UDF;

  modport master (
    output WE, DATA, RE,
    input  Q, DVALID, FULL, EMPTY, AFULL, OVF, UDF
  );

  modport slave (
    input  WE, DATA, RE,
    output Q, DVALID, FULL, EMPTY, AFULL, OVF, UDF
  );
endinterface

// File: rtl/ack_fifo_ctrl.sv
// 64x16 FIFO controller driving an external USRAM (C write port, A read port with registered address).
// Optional macro ACK_FIFO_CTRL_LEVEL_EN adds a registered LEVEL (word count) output.
module ack_fifo_ctrl #(
  parameter int unsigned AFULL_THRESH = 56
) (
  input  logic        CLK,
  input  logic        SRST_N,
  ack_fifo_ctrl_if.slave fifo,
`ifdef ACK_FIFO_CTRL_LEVEL_EN
  output logic [6:0]  LEVEL,
`endif
  output logic [5:0]  RAM_WADDR,
  output logic [15:0] RAM_WDATA,
  output logic        RAM_WEN,
  output logic        RAM_WBLK,
  output logic [5:0]  RAM_RADDR,
  output logic        RAM_RADDR_EN,
  output logic        RAM_RBLK,
  input  logic [15:0] RAM_RDATA
);

  logic [5:0] wp, rp;
  logic [6:0] cnt, cnt_nxt;
  logic       full_q, empty_q, afull_q;
  logic       dvalid_q, ovf_q, udf_q;
  logic       wr_acc, rd_acc;

  // Acceptance uses only registered flags, so a request never sees the flag it changes.
  assign wr_acc = SRST_N & fifo.WE & ~full_q;
  assign rd_acc = SRST_N & fifo.RE & ~empty_q;

  always_comb begin
    cnt_nxt = cnt;
    case ({wr_acc, rd_acc})
      2'b10:   cnt_nxt = cnt + 7'd1;
      2'b01:   cnt_nxt = cnt - 7'd1;
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!SRST_N) begin
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      dvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (wr_acc) wp <= wp + 6'd1;
      if (rd_acc) rp <= rp + 6'd1;
      cnt      <= cnt_nxt;
      full_q   <= (cnt_nxt == 7'd64);
      empty_q  <= (cnt_nxt == 7'd0);
      afull_q  <= (cnt_nxt >= 7'(AFULL_THRESH));
      dvalid_q <= rd_acc;
      ovf_q    <= fifo.WE & full_q;
      udf_q    <= fifo.RE & empty_q;
    end
  end

  assign RAM_WADDR    = wp;
  assign RAM_WDATA    = fifo.DATA;
  assign RAM_WEN      = wr_acc;
  assign RAM_WBLK     = wr_acc;
  // Address register is enabled only on an accepted pop so Q holds the last popped word.
  assign RAM_RADDR    = rp;
  assign RAM_RADDR_EN = rd_acc;
  assign RAM_RBLK     = rd_acc;

  assign fifo.Q       = RAM_RDATA;
  assign fifo.DVALID  = dvalid_q;
  assign fifo.FULL    = full_q;
  assign fifo.EMPTY   = empty_q;
  assign fifo.AFULL   = afull_q;
  assign fifo.OVF     = ovf_q;
  assign fifo.UDF     = udf_q;

`ifdef ACK_FIFO_CTRL_LEVEL_EN
  assign LEVEL = cnt;
`endif

endmodule

// File: tb/tb_ack_fifo_ctrl.sv
// Scoreboard bench for ack_fifo_ctrl: pops queue their expected word and DVALID cycle; a monitor checks them.
module tb_ack_fifo_ctrl;
  logic        clk = 1'b0;
  logic        srst_n;
  logic [5:0]  ram_waddr, ram_raddr;
  logic [15:0] ram_wdata, ram_rdata;
  logic        ram_wen, ram_wblk, ram_raddr_en, ram_rblk;
`ifdef ACK_FIFO_CTRL_LEVEL_EN
  logic [6:0]  level;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic [15:0] d;
    int unsigned at;
  } exp_t;
  exp_t sb[$];

  ack_fifo_ctrl_if bus();

  ack_fifo_ctrl #(.AFULL_THRESH(56)) dut (
    .CLK          (clk),
    .SRST_N       (srst_n),
    .fifo         (bus),
`ifdef ACK_FIFO_CTRL_LEVEL_EN
    .LEVEL        (level),
`endif
    .RAM_WADDR    (ram_waddr),
    .RAM_WDATA    (ram_wdata),
    .RAM_WEN      (ram_wen),
    .RAM_WBLK     (ram_wblk),
    .RAM_RADDR    (ram_raddr),
    .RAM_RADDR_EN (ram_raddr_en),
    .RAM_RBLK     (ram_rblk),
    .RAM_RDATA    (ram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // USRAM model: C port written on clk, A port address registered, data unregistered.
  logic [15:0] mem [64];
  logic [5:0]  raddr_q = '0;
  always @(posedge clk) begin
    if (ram_wen && ram_wblk) mem[ram_waddr] <= ram_wdata;
    if (ram_raddr_en && ram_rblk) raddr_q <= ram_raddr;
  end
  assign ram_rdata = mem[raddr_q];

  // Monitor
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at < cyc) begin
      checks++; errors++;
      $display("FAIL missing_dvalid: expected word %h at cycle %0d, no DVALID by cycle %0d", sb[0].d, sb[0].at, cyc);
      void'(sb.pop_front());
    end
    if (bus.DVALID) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_dvalid: DVALID=1 Q=%h at cycle %0d, required no output", bus.Q, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.Q !== e.d || e.at != cyc) begin
          errors++;
          $display("FAIL pop_data: got Q=%h at cycle %0d, required %h at cycle %0d", bus.Q, cyc, e.d, e.at);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic we, input logic [15:0] d, input logic re);
    bus.WE = we; bus.DATA = d; bus.RE = re;
    @(posedge clk); #1;
    bus.WE = 1'b0; bus.RE = 1'b0; bus.DATA = '0;
  endtask

  task automatic push(input logic [15:0] d);
    tick(1'b1, d, 1'b0);
  endtask

  task automatic pop(input logic [15:0] exp);
    sb.push_back('{d: exp, at: cyc + 1});
    tick(1'b0, '0, 1'b1);
  endtask

  task automatic pushpop(input logic [15:0] d, input logic [15:0] exp);
    sb.push_back('{d: exp, at: cyc + 1});
    tick(1'b1, d, 1'b1);
  endtask

  task automatic check_level(input string name, input logic [6:0] exp);
`ifdef ACK_FIFO_CTRL_LEVEL_EN
    check(name, {25'd0, level}, {25'd0, exp});
`else
    check(name, {31'd0, bus.EMPTY}, {31'd0, (exp == 7'd0)});
`endif
  endtask

  initial begin
    bus.WE = 1'b0; bus.RE = 1'b0; bus.DATA = '0;
    srst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_empty", {31'd0, bus.EMPTY}, 32'd1);
    check("rst_full",  {31'd0, bus.FULL},  32'd0);
    check("rst_afull", {31'd0, bus.AFULL}, 32'd0);
    check("rst_dvalid",{31'd0, bus.DVALID},32'd0);
    check("rst_ovf_udf", {30'd0, bus.OVF, bus.UDF}, 32'd0);
    check_level("rst_level", 7'd0);
    srst_n = 1'b1;

    // Basic three-word push/pop
    push(16'h0001); push(16'h0002); push(16'h0003);
    check("basic_not_empty", {31'd0, bus.EMPTY}, 32'd0);
    pop(16'h0001); pop(16'h0002); pop(16'h0003);
    check("basic_empty", {31'd0, bus.EMPTY}, 32'd1);
    tick(1'b0, '0, 1'b0);

    // Fill to 64, threshold and full flags
    for (int i = 0; i < 64; i++) begin
      push(16'h1000 + 16'(i));
      if (i == 54) check("afull_at_55", {31'd0, bus.AFULL}, 32'd0);
      if (i == 55) check("afull_at_56", {31'd0, bus.AFULL}, 32'd1);
      if (i == 62) check("full_at_63",  {31'd0, bus.FULL},  32'd0);
    end
    check("full_at_64", {31'd0, bus.FULL}, 32'd1);
    check_level("level_64", 7'd64);
    push(16'hDEAD);
    check("ovf_pulse", {31'd0, bus.OVF}, 32'd1);
    check("ovf_still_full", {31'd0, bus.FULL}, 32'd1);
    tick(1'b0, '0, 1'b0);
    check("ovf_one_cycle", {31'd0, bus.OVF}, 32'd0);
    for (int i = 0; i < 64; i++) pop(16'h1000 + 16'(i));
    check("drain_empty", {31'd0, bus.EMPTY}, 32'd1);
    check("drain_afull", {31'd0, bus.AFULL}, 32'd0);
    tick(1'b0, '0, 1'b0);

    // Underflow cases
    tick(1'b0, '0, 1'b1);
    check("udf_pulse", {31'd0, bus.UDF}, 32'd1);
    tick(1'b0, '0, 1'b0);
    check("udf_one_cycle", {31'd0, bus.UDF}, 32'd0);
    tick(1'b1, 16'h0055, 1'b1);
    check("pp_empty_udf", {31'd0, bus.UDF}, 32'd1);
    check("pp_empty_not_empty", {31'd0, bus.EMPTY}, 32'd0);
    check_level("pp_empty_level", 7'd1);
    pop(16'h0055);
    check("pp_empty_drained", {31'd0, bus.EMPTY}, 32'd1);

    // Push+pop while full
    for (int i = 0; i < 64; i++) push(16'h3000 + 16'(i));
    pushpop(16'h3FFF, 16'h3000);
    check("pp_full_ovf", {31'd0, bus.OVF}, 32'd1);
    check("pp_full_full", {31'd0, bus.FULL}, 32'd0);
    check("pp_full_afull", {31'd0, bus.AFULL}, 32'd1);
`ifdef ACK_FIFO_CTRL_LEVEL_EN
    check("pp_full_level", {25'd0, level}, 32'd63);
`endif
    for (int i = 1; i < 64; i++) pop(16'h3000 + 16'(i));
    check("pp_full_drained", {31'd0, bus.EMPTY}, 32'd1);

    // Streaming at depth 10 across pointer wrap
    for (int i = 0; i < 10; i++) push(16'h2000 + 16'(i));
    for (int k = 0; k < 200; k++) pushpop(16'h2000 + 16'(k + 10), 16'h2000 + 16'(k));
    check("stream_flags", {29'd0, bus.FULL, bus.EMPTY, bus.AFULL}, 32'd0);
`ifdef ACK_FIFO_CTRL_LEVEL_EN
    check("stream_level", {25'd0, level}, 32'd10);
`endif

    // Reset mid-stream with requests held active
    srst_n = 1'b0;
    bus.WE = 1'b1; bus.RE = 1'b1; bus.DATA = 16'hBEEF;
    #1;
    check("rst_ram_wen", {31'd0, ram_wen}, 32'd0);
    check("rst_ram_raddr_en", {31'd0, ram_raddr_en}, 32'd0);
    @(posedge clk); #1;
    bus.WE = 1'b0; bus.RE = 1'b0;
    check("mid_rst_empty", {31'd0, bus.EMPTY}, 32'd1);
    check("mid_rst_dvalid", {31'd0, bus.DVALID}, 32'd0);
    check("mid_rst_flags", {28'd0, bus.FULL, bus.AFULL, bus.OVF, bus.UDF}, 32'd0);
    check_level("mid_rst_level", 7'd0);
    srst_n = 1'b1;
    push(16'h00AA);
    push(16'h00BB);
    pop(16'h00AA);
    pop(16'h00BB);
    check("post_rst_empty", {31'd0, bus.EMPTY}, 32'd1);

    repeat (3) tick(1'b0, '0, 1'b0);
    check("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
